// File: rtl/nf_debug_pkg.sv
// Shared constants, state type and record-word helper for the debug snapshot controller.
package nf_debug_pkg;

    localparam int DBG_VEC_W  = 384;
    localparam int DBG_PORT_W = 96;
    localparam int DBG_WORDS  = 12;

    localparam logic [7:0] DBG_HDR_MAGIC = 8'hDB;
    localparam logic [7:0] DBG_HDR_LEN   = 8'(DBG_WORDS);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } dbg_state_t;

    // Payload word k (1..DBG_WORDS) of a record, most significant word first.
    function automatic logic [31:0] dbg_word(input logic [DBG_VEC_W-1:0] v, input logic [3:0] k);
        int idx;
        idx = int'(k) - 1;
        return v[DBG_VEC_W-1-32*idx -: 32];
    endfunction

endpackage

// File: rtl/nf_debug_period_timer.sv
// Free-running 0..PERIOD_CYCLES-1 counter producing a one-cycle tick at the terminal count.
module nf_debug_period_timer #(
    parameter int unsigned PERIOD_CYCLES = 100000000
) (
    input  logic clk,
    input  logic resetn,
    input  logic enable,
    output logic tick
);

    localparam int unsigned CNT_W = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
    localparam logic [CNT_W-1:0] TERM = CNT_W'((PERIOD_CYCLES == 0) ? 0 : PERIOD_CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt <= '0;
        end else if (!enable || cnt == TERM) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = enable && (cnt == TERM);

endmodule

// File: rtl/nf_debug_snapshot_ctrl.sv
// Captures the 384-bit debug vector on a software or periodic trigger and streams it as a
// 13-beat record. Define DBG_CHANGE_DETECT_EN to skip periodic records of an unchanged vector.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | no record in flight; waiting for a trigger or pending flag
// ST_SEND | streaming header + 12 shadow words, one per handshake
module nf_debug_snapshot_ctrl
    import nf_debug_pkg::*;
#(
    parameter int unsigned PERIOD_CYCLES = 100000000
) (
    input  logic                 axi_aclk,
    input  logic                 axi_resetn,
    input  logic [DBG_VEC_W-1:0] debug_vector,
    input  logic                 snapshot_req,
    output logic [31:0]          m_axis_tdata,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic                 m_axis_tlast,
    output logic                 busy,
    output logic [15:0]          seq_num,
    output logic [15:0]          drop_cnt
);

    localparam bit         TIMER_EN  = (PERIOD_CYCLES != 0);
    localparam logic [3:0] LAST_BEAT = 4'(DBG_WORDS);

    dbg_state_t           state;
    logic [3:0]           beat;
    logic [DBG_VEC_W-1:0] shadow;
    logic                 pending;
    logic                 tick;
    logic                 trig;
    logic                 hs;
    logic                 skip;

    nf_debug_period_timer #(
        .PERIOD_CYCLES(PERIOD_CYCLES)
    ) u_timer (
        .clk    (axi_aclk),
        .resetn (axi_resetn),
        .enable (TIMER_EN),
        .tick   (tick)
    );

    assign trig = snapshot_req | tick;
    assign hs   = m_axis_tvalid & m_axis_tready;
    assign busy = (state == ST_SEND) | pending;

`ifdef DBG_CHANGE_DETECT_EN
    logic [DBG_VEC_W-1:0] last_sent;
    logic                 last_valid;
    logic                 pend_sw;

    // A trigger is timer-only unless a software request is present now or is what set pending.
    assign skip = !(snapshot_req | (pending & pend_sw)) && last_valid && (debug_vector == last_sent);

    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            last_sent  <= '0;
            last_valid <= 1'b0;
            pend_sw    <= 1'b0;
        end else begin
            if (state == ST_SEND && hs && beat == LAST_BEAT) begin
                last_sent  <= shadow;
                last_valid <= 1'b1;
            end
            if (state == ST_SEND && trig && !pending) begin
                pend_sw <= snapshot_req;
            end
        end
    end
`else
    assign skip = 1'b0;
`endif

    always_ff @(posedge axi_aclk or negedge axi_resetn) begin
        if (!axi_resetn) begin
            state         <= ST_IDLE;
            beat          <= '0;
            shadow        <= '0;
            pending       <= 1'b0;
            seq_num       <= '0;
            drop_cnt      <= '0;
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
        end else begin
            // Triggers arriving mid-record, including on the final handshake, queue or drop.
            if (state == ST_SEND && trig) begin
                if (pending) begin
                    if (drop_cnt != 16'hFFFF) begin
                        drop_cnt <= drop_cnt + 16'd1;
                    end
                end else begin
                    pending <= 1'b1;
                end
            end

            case (state)
                ST_IDLE: begin
                    if (trig || pending) begin
                        pending <= 1'b0;
                        if (!skip) begin
                            shadow        <= debug_vector;
                            beat          <= '0;
                            state         <= ST_SEND;
                            m_axis_tvalid <= 1'b1;
                            m_axis_tlast  <= 1'b0;
                            m_axis_tdata  <= {DBG_HDR_MAGIC, DBG_HDR_LEN, seq_num};
                        end
                    end
                end
                ST_SEND: begin
                    if (hs) begin
                        if (beat == LAST_BEAT) begin
                            state         <= ST_IDLE;
                            m_axis_tvalid <= 1'b0;
                            m_axis_tlast  <= 1'b0;
                            seq_num       <= seq_num + 16'd1;
                        end else begin
                            beat         <= beat + 4'd1;
                            m_axis_tdata <= dbg_word(shadow, beat + 4'd1);
                            m_axis_tlast <= (beat + 4'd1 == LAST_BEAT);
                        end
                    end
                end
            endcase
        end
    end

endmodule
